vga_sprite_engine: RTL and testbench
====================================

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

Interface
REQ-001 Parameter N_SPR, 2: sprite count, 1..8, SHALL be supported.
REQ-002 Parameter SPR_W, 32: sprite width in pixels.
REQ-003 Parameter SPR_H, 32: sprite height in pixels.
REQ-004 Parameter STEP, 4: pixels moved per frame tick per active direction, 1..15.
REQ-005 Parameter WRAP, 1: 1 = toroidal wrap at screen edge, 0 = clamp.
REQ-006 in_clk  in  1  system clock; only clock in the block.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 pix_ce  in  1  pixel-clock enable strobe; all pixel-domain state advances only when high.
REQ-009 hcnt, vcnt  in  11 each  current pixel coordinates from timing generator.
REQ-010 blank  in  1  high outside the active area.
REQ-011 hs_in, vs_in  in  1 each  raw syncs.
REQ-012 up, down, left, right  in  N_SPR each  per-sprite direction requests, bit i = sprite i.
REQ-013 spr_en  in  N_SPR  per-sprite enable.
REQ-014 spr_rgb  in  12*N_SPR  per-sprite colour, {r,g,b} 4 bits each, sprite i at [12i+11:12i].
REQ-015 bg_rgb  in  12  background colour.
REQ-016 vga_r, vga_g, vga_b  out  4 each  registered pixel colour.
REQ-017 hs, vs  out  1 each  syncs delayed to align with colour.
REQ-018 collision  out  N_SPR  per-sprite overlap flags for the previous frame.

Function
REQ-019 frame_tick SHALL be a single in_clk pulse when pix_ce=1, hcnt=0, vcnt=V_ACTIVE.
REQ-020 Positions x_i (11 bit, 0..H_ACTIVE-1) and y_i (11 bit, 0..V_ACTIVE-1) SHALL change only on frame_tick, so no frame tears.
REQ-021 On frame_tick, with sprite enabled, left SHALL subtract STEP from x_i, right add STEP, up subtract STEP from y_i, down add STEP.
REQ-022 Simultaneous left&right or up&down SHALL leave that axis unchanged.
REQ-023 A disabled sprite SHALL hold its position and be invisible.
REQ-024 WRAP=1: result SHALL be taken modulo H_ACTIVE / V_ACTIVE, including negative underflow (x=2, left, STEP=4 -> x=638).
REQ-025 WRAP=0: x SHALL saturate to 0..H_ACTIVE-SPR_W and y to 0..V_ACTIVE-SPR_H.
REQ-026 Hit_i SHALL be true when spr_en[i], x_i<=hcnt<=x_i+SPR_W-1, and y_i<=vcnt<=y_i+SPR_H-1; pixels beyond the screen edge are clipped, not split.
REQ-027 Priority: lowest-index hit sprite SHALL win; with no hit, bg_rgb SHALL be output.
REQ-028 Colour, hs and vs outputs SHALL register on pix_ce with exactly one pix_ce latency from hcnt/vcnt/hs_in/vs_in.
REQ-029 When blank=1, colour outputs SHALL be 0 regardless of sprites.
REQ-030 Accumulator bit i SHALL set when hit_i and at least one other hit_j occur on the same visible pixel.
REQ-031 On frame_tick, collision SHALL load from the accumulator and the accumulator SHALL clear in the same cycle; a hit on that same cycle lands in the new accumulator.

Reset
REQ-032 On rst: x_i = i*2*SPR_W; y_i = (V_ACTIVE-SPR_H)/2.
REQ-033 On rst: vga_r/g/b = 0, hs = 1, vs = 1, collision = 0, accumulator = 0.
REQ-034 rst asserted mid-frame SHALL take effect on the next in_clk edge, independent of pix_ce.
REQ-035 Elaboration SHALL fail if N_SPR*2*SPR_W > H_ACTIVE.

Structure
REQ-036 Shared package vga_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, the 12-bit rgb type and the colour field offsets.
REQ-037 A per-sprite sub-module sprite_pos SHALL hold position state, the move/wrap/clamp logic and the hit test; N_SPR instances are generated.

Verification
REQ-038 Reset, then run one frame -> sprite0 drawn at x 0..31, y 224..255; sprite1 drawn at x 64..95; outputs 0 during blank.
REQ-039 WRAP=1, sprite0 x=2, hold left one frame -> x=638; x=636, hold right -> x=0.
REQ-040 WRAP=0, hold up for 100 frames -> y=0; hold right for 200 frames -> x=608.
REQ-041 left&right held together for 5 frames -> x unchanged; up alone -> y decreases by 4 per frame_tick only.
REQ-042 Move sprite1 to overlap sprite0 -> overlap pixels show spr_rgb[11:0]; collision=2'b11 after the next frame_tick; separate them -> 2'b00 one frame later.
REQ-043 Assert rst at vcnt=100 mid-move -> reset positions and all-zero outputs on the next edge; pix_ce=0 for 10 cycles -> outputs and positions frozen.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared display constants and colour types for the sprite engine.
//   H_ACTIVE / V_ACTIVE : visible raster size
//   rgb_t               : 12-bit {r,g,b} colour, 4 bits per channel
//   R_OFS/G_OFS/B_OFS   : bit offsets of each channel inside rgb_t
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [11:0] rgb_t;

  localparam int R_OFS = 8;
  localparam int G_OFS = 4;
  localparam int B_OFS = 0;
endpackage

// File: rtl/sprite_pos.sv
// sprite_pos: position state, per-frame movement and pixel hit test for one sprite.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_frame_tick      : one-cycle strobe at the start of vertical blank
//   i_en              : sprite enable (disabled = frozen and invisible)
//   i_up/down/left/right : direction requests sampled on i_frame_tick
//   i_hcnt, i_vcnt    : current pixel coordinate
//   o_hit             : current pixel lies inside this sprite
module sprite_pos
  import vga_pkg::*;
#(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int STEP   = 4,
  parameter int WRAP   = 1,
  parameter int INIT_X = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_en,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  input  logic [10:0] i_hcnt,
  input  logic [10:0] i_vcnt,
  output logic        o_hit
);
  localparam logic [10:0] INIT_Y = 11'((V_ACTIVE - SPR_H) / 2);

  logic [10:0] r_x, r_y;
  logic [10:0] w_nx, w_ny;
  logic [11:0] w_xe, w_ye;

  // One axis step. STEP < lim, so a single add/subtract of lim is enough to
  // bring a wrapped coordinate back into range. Opposing requests cancel.
  function automatic logic [10:0] step_axis(input logic [10:0] p, input logic dec,
                                            input logic inc, input int lim, input int sz);
    int n;
    n = {21'd0, p};
    if (dec && !inc)      n = n - STEP;
    else if (inc && !dec) n = n + STEP;
    if (WRAP != 0) begin
      if (n < 0)         n = n + lim;
      else if (n >= lim) n = n - lim;
    end else begin
      if (n < 0)             n = 0;
      else if (n > lim - sz) n = lim - sz;
    end
    return n[10:0];
  endfunction

  assign w_nx = step_axis(r_x, i_left, i_right, H_ACTIVE, SPR_W);
  assign w_ny = step_axis(r_y, i_up,   i_down,  V_ACTIVE, SPR_H);

  // Far edges computed one bit wider so a sprite hanging off the right or
  // bottom edge is clipped rather than wrapped onto the opposite side.
  assign w_xe = {1'b0, r_x} + 12'(SPR_W - 1);
  assign w_ye = {1'b0, r_y} + 12'(SPR_H - 1);

  assign o_hit = i_en && (i_hcnt >= r_x) && ({1'b0, i_hcnt} <= w_xe)
                      && (i_vcnt >= r_y) && ({1'b0, i_vcnt} <= w_ye);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x <= 11'(INIT_X);
      r_y <= INIT_Y;
    end else if (i_frame_tick && i_en) begin
      r_x <= w_nx;
      r_y <= w_ny;
    end
  end
endmodule

// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: overlays N_SPR movable rectangular sprites on a background.
//   in_clk, rst            : clock, synchronous active-high reset
//   pix_ce                 : pixel-clock enable
//   hcnt, vcnt, blank      : raster position / blanking from the timing generator
//   hs_in, vs_in           : raw syncs, delayed by one pixel to match colour
//   up/down/left/right     : per-sprite movement requests (bit i = sprite i)
//   spr_en, spr_rgb, bg_rgb: sprite enables, sprite colours, background colour
//   vga_r/g/b, hs, vs      : registered video out
//   collision              : per-sprite overlap flags from the previous frame
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int N_SPR = 2,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int STEP  = 4,
  parameter int WRAP  = 1
) (
  input  logic                 in_clk,
  input  logic                 rst,
  input  logic                 pix_ce,
  input  logic [10:0]          hcnt,
  input  logic [10:0]          vcnt,
  input  logic                 blank,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic [N_SPR-1:0]     up,
  input  logic [N_SPR-1:0]     down,
  input  logic [N_SPR-1:0]     left,
  input  logic [N_SPR-1:0]     right,
  input  logic [N_SPR-1:0]     spr_en,
  input  logic [12*N_SPR-1:0]  spr_rgb,
  input  logic [11:0]          bg_rgb,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b,
  output logic                 hs,
  output logic                 vs,
  output logic [N_SPR-1:0]     collision
);
  // Initial sprite placement needs room for every sprite side by side.
  if (N_SPR < 1 || N_SPR > 8 || N_SPR * 2 * SPR_W > H_ACTIVE) begin : g_bad_cfg
    $error("vga_sprite_engine: unsupported N_SPR/SPR_W combination");
  end

  logic               w_tick;
  logic [N_SPR-1:0]   w_hit;
  logic [N_SPR-1:0]   w_acc_set;
  logic               w_multi;
  rgb_t               w_pix;
  logic [N_SPR-1:0]   r_acc;

  // First pixel of the first blank line: positions move while nothing is drawn.
  assign w_tick = pix_ce && (hcnt == 11'd0) && (vcnt == 11'(V_ACTIVE));

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    sprite_pos #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .STEP   (STEP),
      .WRAP   (WRAP),
      .INIT_X (i * 2 * SPR_W)
    ) u_pos (
      .i_clk        (in_clk),
      .i_rst        (rst),
      .i_frame_tick (w_tick),
      .i_en         (spr_en[i]),
      .i_up         (up[i]),
      .i_down       (down[i]),
      .i_left       (left[i]),
      .i_right      (right[i]),
      .i_hcnt       (hcnt),
      .i_vcnt       (vcnt),
      .o_hit        (w_hit[i])
    );
  end

  // Scan from the top index down so the lowest-index hit is written last and wins.
  always_comb begin
    w_pix = bg_rgb;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (w_hit[i]) w_pix = spr_rgb[12*i +: 12];
  end

  // Clearing the lowest set bit leaves something only when two or more sprites hit.
  assign w_multi   = |(w_hit & (w_hit - N_SPR'(1)));
  assign w_acc_set = (pix_ce && !blank && w_multi) ? w_hit : '0;

  always_ff @(posedge in_clk) begin
    if (rst) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      hs        <= 1'b1;
      vs        <= 1'b1;
      collision <= '0;
      r_acc     <= '0;
    end else begin
      if (pix_ce) begin
        if (blank) begin
          vga_r <= '0;
          vga_g <= '0;
          vga_b <= '0;
        end else begin
          vga_r <= w_pix[R_OFS +: 4];
          vga_g <= w_pix[G_OFS +: 4];
          vga_b <= w_pix[B_OFS +: 4];
        end
        hs <= hs_in;
        vs <= vs_in;
      end
      // A hit coinciding with the tick belongs to the frame just starting.
      if (w_tick) begin
        collision <= r_acc;
        r_acc     <= w_acc_set;
      end else begin
        r_acc <= r_acc | w_acc_set;
      end
    end
  end
endmodule

// File: tb/tb_vga_sprite_engine.sv
module tb_vga_sprite_engine;
  localparam int N = 2, SW = 32, SH = 32, ST = 4, HA = 640, VA = 480;

  logic        clk = 1'b0;
  logic        rst, pix_ce, blank, hs_in, vs_in;
  logic [10:0] hcnt, vcnt;
  logic [1:0]  up, down, left, right, spr_en;
  logic [23:0] spr_rgb;
  logic [11:0] bg_rgb;

  // Instance 0 wraps, instance 1 clamps; both see identical stimulus.
  logic [3:0] o_r [2], o_g [2], o_b [2];
  logic       o_hs [2], o_vs [2];
  logic [1:0] o_col [2];

  always #5 clk = ~clk;

  vga_sprite_engine #(.N_SPR(N), .SPR_W(SW), .SPR_H(SH), .STEP(ST), .WRAP(1)) u_wrap (
    .in_clk(clk), .rst(rst), .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .blank(blank),
    .hs_in(hs_in), .vs_in(vs_in), .up(up), .down(down), .left(left), .right(right),
    .spr_en(spr_en), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
    .vga_r(o_r[0]), .vga_g(o_g[0]), .vga_b(o_b[0]), .hs(o_hs[0]), .vs(o_vs[0]),
    .collision(o_col[0]));

  vga_sprite_engine #(.N_SPR(N), .SPR_W(SW), .SPR_H(SH), .STEP(ST), .WRAP(0)) u_clmp (
    .in_clk(clk), .rst(rst), .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .blank(blank),
    .hs_in(hs_in), .vs_in(vs_in), .up(up), .down(down), .left(left), .right(right),
    .spr_en(spr_en), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
    .vga_r(o_r[1]), .vga_g(o_g[1]), .vga_b(o_b[1]), .hs(o_hs[1]), .vs(o_vs[1]),
    .collision(o_col[1]));

  // Reference model state, per instance
  int         mx [2][2], my [2][2];
  logic [1:0] macc [2], mcol [2];
  logic [11:0] mrgb [2];
  logic       mhs, mvs;
  int         vectors = 0, miscompares = 0;
  string      phase = "reset";

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < N; i++) begin
        mx[w][i] = i * 2 * SW;
        my[w][i] = (VA - SH) / 2;
      end
      mrgb[w] = 12'h000; macc[w] = 2'b00; mcol[w] = 2'b00;
    end
    mhs = 1'b1; mvs = 1'b1;
  endtask

  function automatic bit covers(int w, int i, int h, int v);
    return spr_en[i] && h >= mx[w][i] && h < mx[w][i] + SW && v >= my[w][i] && v < my[w][i] + SH;
  endfunction

  function automatic logic [11:0] model_pix(int w, int h, int v, logic b);
    if (b) return 12'h000;
    for (int i = 0; i < N; i++)
      if (covers(w, i, h, v)) return spr_rgb[12*i +: 12];
    return bg_rgb;
  endfunction

  function automatic int mv(int p, logic dec, logic inc, int lim, int sz, bit wrap);
    int n;
    n = p;
    if (inc && !dec) n = n + ST;
    if (dec && !inc) n = n - ST;
    if (wrap) return ((n % lim) + lim) % lim;
    if (n < 0) return 0;
    if (n > lim - sz) return lim - sz;
    return n;
  endfunction

  // Present one pixel, let one edge pass, advance the model, compare both DUTs.
  task automatic step_pix(input int h, input int v, input logic b, input logic ce);
    hcnt = h[10:0]; vcnt = v[10:0]; blank = b; pix_ce = ce;
    hs_in = 1'($urandom); vs_in = 1'($urandom);
    @(posedge clk); #1;
    if (rst) model_reset();
    else if (ce) begin
      for (int w = 0; w < 2; w++) begin
        logic [1:0] hitv;
        int nh;
        hitv = 2'b00; nh = 0;
        mrgb[w] = model_pix(w, h, v, b);
        if (!b)
          for (int i = 0; i < N; i++)
            if (covers(w, i, h, v)) begin hitv[i] = 1'b1; nh++; end
        if (nh < 2) hitv = 2'b00;
        if (h == 0 && v == VA) begin
          mcol[w] = macc[w];
          macc[w] = hitv;
          for (int i = 0; i < N; i++)
            if (spr_en[i]) begin
              mx[w][i] = mv(mx[w][i], left[i], right[i], HA, SW, w == 0);
              my[w][i] = mv(my[w][i], up[i], down[i], VA, SH, w == 0);
            end
        end else macc[w] = macc[w] | hitv;
      end
      mhs = hs_in; mvs = vs_in;
    end
    for (int w = 0; w < 2; w++) begin
      vectors++;
      assert ({o_r[w], o_g[w], o_b[w], o_hs[w], o_vs[w], o_col[w]} === {mrgb[w], mhs, mvs, mcol[w]})
      else begin
        miscompares++;
        $error("FAIL %s dut%0d h=%0d v=%0d observed=%h expected=%h", phase, w, h, v,
               {o_r[w], o_g[w], o_b[w], o_hs[w], o_vs[w], o_col[w]}, {mrgb[w], mhs, mvs, mcol[w]});
      end
    end
  endtask

  task automatic tick();
    step_pix(0, VA, 1'b1, 1'b1);
  endtask

  // Probe the edges of every modelled sprite plus a few random pixels.
  task automatic probe();
    int px[$], py[$];
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < N; i++) begin
        int x, y;
        x = mx[w][i]; y = my[w][i];
        px = {px, x, x + SW - 1, x - 1, x + SW, x, x, 0, HA - 1};
        py = {py, y, y + SH - 1, y, y, y - 1, y + SH, y, y};
      end
    repeat (6) begin
      px.push_back(int'($urandom_range(HA - 1)));
      py.push_back(int'($urandom_range(VA - 1)));
    end
    foreach (px[k])
      if (px[k] >= 0 && px[k] < HA && py[k] >= 0 && py[k] < VA)
        step_pix(px[k], py[k], 1'b0, 1'b1);
  endtask

  initial begin
    up = '0; down = '0; left = '0; right = '0; spr_en = 2'b11;
    spr_rgb = {12'h0F0, 12'hF00}; bg_rgb = 12'h00F;
    rst = 1'b1;
    repeat (3) step_pix(int'($urandom_range(HA - 1)), int'($urandom_range(VA - 1)), 1'b0, 1'b1);
    rst = 1'b0;

    phase = "initial_draw";
    spr_rgb = {12'($urandom), 12'($urandom)}; bg_rgb = 12'($urandom);
    probe();
    phase = "blank_zero";
    step_pix(10, 230, 1'b1, 1'b1);
    step_pix(70, 240, 1'b1, 1'b1);

    phase = "wrap_left";  left = 2'b01;  tick(); left = '0;  probe();
    phase = "wrap_right"; right = 2'b01; tick(); right = '0; probe();

    phase = "up_100";    up = 2'b01;    repeat (100) tick(); up = '0;    probe();
    phase = "right_200"; right = 2'b01; repeat (200) tick(); right = '0; probe();

    phase = "cancel_lr"; left = 2'b01; right = 2'b01; repeat (5) tick(); probe();
    left = '0; right = '0;
    phase = "up_alone";  up = 2'b01;
    repeat (3) begin tick(); probe(); end
    up = '0;

    phase = "random";
    repeat (30) begin
      {up, down, left, right} = 8'($urandom);
      spr_en = 2'($urandom);
      spr_rgb = {12'($urandom), 12'($urandom)};
      tick(); probe();
    end
    up = '0; down = '0; left = '0; right = '0; spr_en = 2'b11;

    phase = "overlap";
    rst = 1'b1; step_pix(5, 5, 1'b0, 1'b1); rst = 1'b0;
    left = 2'b10; repeat (12) tick(); left = '0;
    probe();
    step_pix(20, 230, 1'b0, 1'b1);
    tick(); tick();
    phase = "separate";
    right = 2'b10; repeat (12) tick(); right = '0;
    probe(); tick(); tick();

    phase = "freeze";
    left = 2'b11; up = 2'b11;
    repeat (10) step_pix(0, VA, 1'b0, 1'b0);
    repeat (10) step_pix(int'($urandom_range(HA - 1)), int'($urandom_range(VA - 1)), 1'b0, 1'b0);
    left = '0; up = '0;
    probe();

    phase = "midframe_rst";
    up = 2'b01; right = 2'b10;
    repeat (3) tick();
    step_pix(50, 100, 1'b0, 1'b1);
    rst = 1'b1; step_pix(60, 100, 1'b0, 1'b0); rst = 1'b0;
    up = '0; right = '0;
    probe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
